// File: rtl/debounce_pkg.sv
// debounce_pkg
//   Shared definitions for the multi-channel debouncer: the state width and
//   the per-channel FSM state encoding.
package debounce_pkg;

   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ZERO  = 2'b00,
      WAIT0 = 2'b01,
      ONE   = 2'b10,
      WAIT1 = 2'b11
   } db_state_e;

endpackage : debounce_pkg

// File: rtl/debounce_ch.sv
// debounce_ch
//   One debounce channel: SYNC_STAGES-deep synchroniser, 4-state debounce FSM
//   with reload/decrement counter, registered level and one-cycle rise/fall
//   ticks. The input must be stable for 2^CNT_BITS consecutive synchronised
//   samples before the level changes.
//   Optional long-press detection is compiled in with `define DEBOUNCE_HOLD_EN.
// Ports:
//   clk_i    system clock, rising edge
//   rst_i    asynchronous active-high reset
//   sw_i     raw asynchronous switch input
//   level_o  debounced level
//   rise_o   one-cycle pulse on a debounced 0->1 transition
//   fall_o   one-cycle pulse on a debounced 1->0 transition
//   hold_o   one-cycle long-press pulse (0 when DEBOUNCE_HOLD_EN is undefined)
module debounce_ch
   import debounce_pkg::*;
#(
   parameter int unsigned CNT_BITS    = 20,
   parameter int unsigned SYNC_STAGES = 2
`ifdef DEBOUNCE_HOLD_EN
   ,
   parameter int unsigned HOLD_BITS   = 26
`endif
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sw_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o,
   output logic hold_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   db_state_e              state_q;
   logic [CNT_BITS-1:0]    cnt_q;
   logic [CNT_BITS-1:0]    cnt_dec;
   logic                   press_done;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i};
      end
   end

   assign s       = sync_q[SYNC_STAGES-1];
   assign cnt_dec = cnt_q - CNT_BITS'(1);

   // Last decrement of a press: the FSM enters ONE on this edge.
   assign press_done = (state_q == WAIT1) && s && (cnt_dec == '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ZERO;
         cnt_q   <= '0;
         level_o <= 1'b0;
         rise_o  <= 1'b0;
         fall_o  <= 1'b0;
      end else begin
         rise_o <= 1'b0;
         fall_o <= 1'b0;
         case (state_q)
            ZERO: begin
               if (s) begin
                  state_q <= WAIT1;
                  cnt_q   <= '1;
               end
            end
            WAIT1: begin
               if (s) begin
                  cnt_q <= cnt_dec;
                  if (cnt_dec == '0) begin
                     state_q <= ONE;
                     level_o <= 1'b1;
                     rise_o  <= 1'b1;
                  end
               end else begin
                  state_q <= ZERO;
               end
            end
            ONE: begin
               if (!s) begin
                  state_q <= WAIT0;
                  cnt_q   <= '1;
               end
            end
            WAIT0: begin
               if (!s) begin
                  cnt_q <= cnt_dec;
                  if (cnt_dec == '0) begin
                     state_q <= ZERO;
                     level_o <= 1'b0;
                     fall_o  <= 1'b1;
                  end
               end else begin
                  state_q <= ONE;
               end
            end
            default: begin
               state_q <= ZERO;
               level_o <= 1'b0;
            end
         endcase
      end
   end

`ifdef DEBOUNCE_HOLD_EN
   logic [HOLD_BITS-1:0] hold_q;
   logic [HOLD_BITS-1:0] hold_inc;

   assign hold_inc = hold_q + HOLD_BITS'(1);

   // Counter is cleared only by a fresh press; WAIT0 freezes it and a return
   // to ONE resumes from the frozen value, so saturation prevents a re-pulse.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hold_q <= '0;
         hold_o <= 1'b0;
      end else begin
         hold_o <= 1'b0;
         if (press_done) begin
            hold_q <= '0;
         end else if ((state_q == ONE) && (hold_q != '1)) begin
            hold_q <= hold_inc;
            if (hold_inc == '1) begin
               hold_o <= 1'b1;
            end
         end
      end
   end
`else
   logic unused_press;
   assign unused_press = press_done;
   assign hold_o       = 1'b0;
`endif

endmodule : debounce_ch

// File: rtl/debounce_multi.sv
// debounce_multi
//   N_CH independent switch debouncers on a common clock. Each bit of sw_i is
//   synchronised and debounced by its own debounce_ch instance.
//   Optional long-press output enabled with `define DEBOUNCE_HOLD_EN (adds
//   parameter HOLD_BITS); otherwise db_hold_o is constant 0.
// Ports:
//   clk_i       system clock, rising edge
//   rst_i       asynchronous active-high reset
//   sw_i        raw switch inputs, bit i = channel i
//   db_level_o  debounced level per channel
//   db_rise_o   one-cycle debounced rise tick per channel
//   db_fall_o   one-cycle debounced fall tick per channel
//   db_hold_o   one-cycle long-press tick per channel
module debounce_multi #(
   parameter int unsigned N_CH        = 4,
   parameter int unsigned CNT_BITS    = 20,
   parameter int unsigned SYNC_STAGES = 2
`ifdef DEBOUNCE_HOLD_EN
   ,
   parameter int unsigned HOLD_BITS   = 26
`endif
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [N_CH-1:0] sw_i,
   output logic [N_CH-1:0] db_level_o,
   output logic [N_CH-1:0] db_rise_o,
   output logic [N_CH-1:0] db_fall_o,
   output logic [N_CH-1:0] db_hold_o
);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      debounce_ch #(
         .CNT_BITS    (CNT_BITS),
         .SYNC_STAGES (SYNC_STAGES)
`ifdef DEBOUNCE_HOLD_EN
         ,
         .HOLD_BITS   (HOLD_BITS)
`endif
      ) u_ch (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .sw_i    (sw_i[g]),
         .level_o (db_level_o[g]),
         .rise_o  (db_rise_o[g]),
         .fall_o  (db_fall_o[g]),
         .hold_o  (db_hold_o[g])
      );
   end

endmodule : debounce_multi

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi
//   Self-checking bench for debounce_multi (N_CH=4, CNT_BITS=3, SYNC_STAGES=2,
//   HOLD_BITS=5 when DEBOUNCE_HOLD_EN is defined). A reference model tracks,
//   per channel, how many consecutive synchronised samples disagree with the
//   debounced level; 2^CNT_BITS of them flip the level.
module tb_debounce_multi;

   localparam int unsigned N_CH     = 4;
   localparam int unsigned CNT_BITS = 3;
   localparam int unsigned SYNC     = 2;
   localparam int unsigned STABLE   = 1 << CNT_BITS;
`ifdef DEBOUNCE_HOLD_EN
   localparam int unsigned HOLD_BITS = 5;
   localparam int unsigned HOLD_MAX  = (1 << HOLD_BITS) - 1;
`endif

   logic            clk;
   logic            rst;
   logic [N_CH-1:0] sw;
   logic [N_CH-1:0] db_level;
   logic [N_CH-1:0] db_rise;
   logic [N_CH-1:0] db_fall;
   logic [N_CH-1:0] db_hold;

   int unsigned checks_n = 0;
   int unsigned fails_n  = 0;

   debounce_multi #(
      .N_CH        (N_CH),
      .CNT_BITS    (CNT_BITS),
      .SYNC_STAGES (SYNC)
`ifdef DEBOUNCE_HOLD_EN
      ,
      .HOLD_BITS   (HOLD_BITS)
`endif
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .sw_i       (sw),
      .db_level_o (db_level),
      .db_rise_o  (db_rise),
      .db_fall_o  (db_fall),
      .db_hold_o  (db_hold)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state.
   logic        m_pipe [N_CH][SYNC];
   logic        m_level[N_CH];
   int unsigned m_run  [N_CH];
   int unsigned m_hold [N_CH];
   logic [N_CH-1:0] exp_level, exp_rise, exp_fall, exp_hold;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_n++;
      if (got !== exp) begin
         fails_n++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N_CH; i++) begin
         for (int k = 0; k < SYNC; k++) m_pipe[i][k] = 1'b0;
         m_level[i] = 1'b0;
         m_run[i]   = 0;
         m_hold[i]  = 0;
      end
      exp_level = '0; exp_rise = '0; exp_fall = '0; exp_hold = '0;
   endtask

   // One clock edge: uses pre-edge synchronised samples, then shifts v in.
   task automatic model_step(input logic [N_CH-1:0] v);
      exp_rise = '0; exp_fall = '0; exp_hold = '0;
      for (int i = 0; i < N_CH; i++) begin
         logic s;
         s = m_pipe[i][SYNC-1];
`ifdef DEBOUNCE_HOLD_EN
         if (m_level[i] && m_run[i] == 0 && m_hold[i] < HOLD_MAX) begin
            m_hold[i]++;
            if (m_hold[i] == HOLD_MAX) exp_hold[i] = 1'b1;
         end
`endif
         if (s != m_level[i]) begin
            m_run[i]++;
            if (m_run[i] == STABLE) begin
               m_level[i] = s;
               m_run[i]   = 0;
               if (s) begin
                  exp_rise[i] = 1'b1;
                  m_hold[i]   = 0;
               end else begin
                  exp_fall[i] = 1'b1;
               end
            end
         end else begin
            m_run[i] = 0;
         end
         for (int k = SYNC - 1; k > 0; k--) m_pipe[i][k] = m_pipe[i][k-1];
         m_pipe[i][0] = v[i];
         exp_level[i] = m_level[i];
      end
   endtask

   task automatic compare_all();
      check_eq("level", 32'(db_level), 32'(exp_level));
      check_eq("rise",  32'(db_rise),  32'(exp_rise));
      check_eq("fall",  32'(db_fall),  32'(exp_fall));
      check_eq("hold",  32'(db_hold),  32'(exp_hold));
   endtask

   task automatic tick(input logic [N_CH-1:0] v);
      sw = v;
      @(posedge clk);
      model_step(v);
      #1;
      compare_all();
   endtask

   // Asserted away from the clock edge to show the asynchronous clear.
   task automatic reset_dut();
      rst = 1'b1;
      #1;
      model_reset();
      check_eq("rst_level", 32'(db_level), 32'h0);
      check_eq("rst_rise",  32'(db_rise),  32'h0);
      check_eq("rst_fall",  32'(db_fall),  32'h0);
      check_eq("rst_hold",  32'(db_hold),  32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int unsigned lat;
      int unsigned n_rise;
      int unsigned n_fall;
      int unsigned rise_at;
      int unsigned hold_at;
      int unsigned n_hold;
      int unsigned rem [N_CH];
      logic [N_CH-1:0] rv;

      sw  = '0;
      rst = 1'b1;
      model_reset();
      #2;
      reset_dut();

      // Single-channel step on channel 0.
      lat = 0;
      for (int i = 1; i <= 12; i++) begin
         tick(4'b0001);
         if (db_level[0] && lat == 0) begin
            lat = i;
            check_eq("step_rise_vec", 32'(db_rise), 32'h1);
         end
      end
      check_eq("step_latency", lat, 32'(SYNC + STABLE));

      // Five-cycle glitch on channel 1 must be ignored.
      repeat (5) tick(4'b0011);
      n_rise = 0;
      for (int i = 0; i < 12; i++) begin
         tick(4'b0001);
         if (db_rise[1] || db_fall[1] || db_level[1]) n_rise++;
      end
      check_eq("glitch_ch1", n_rise, 0);

      // Bounce on channel 2: 3-cycle segments, finishing high.
      for (int k = 0; k < 11; k++) repeat (3) tick((k % 2 == 0) ? 4'b0101 : 4'b0001);
      n_rise = 0; lat = 0;
      for (int i = 1; i <= 15; i++) begin
         tick(4'b0101);
         if (db_rise[2]) begin n_rise++; if (lat == 0) lat = i + 3; end
      end
      check_eq("bounce_rises", n_rise, 1);
      check_eq("bounce_latency", lat, 32'(SYNC + STABLE));
      n_fall = 0;
      for (int i = 0; i < 15; i++) begin
         tick(4'b0001);
         if (db_fall[2]) n_fall++;
      end
      check_eq("bounce_falls", n_fall, 1);

      // All channels together.
      repeat (12) tick(4'b0000);
      n_rise = 0;
      for (int i = 0; i < 12; i++) begin
         tick(4'b1111);
         if (db_rise == 4'b1111) n_rise++;
      end
      check_eq("all_rise_together", n_rise, 1);
      n_fall = 0;
      for (int i = 0; i < 12; i++) begin
         tick(4'b0000);
         if (db_fall == 4'b1111) n_fall++;
      end
      check_eq("all_fall_together", n_fall, 1);

      // Long press on channel 0.
      rise_at = 0; hold_at = 0; n_hold = 0;
      for (int i = 1; i <= 55; i++) begin
         tick(4'b0001);
         if (db_rise[0]) rise_at = i;
         if (db_hold[0]) begin n_hold++; hold_at = i; end
      end
`ifdef DEBOUNCE_HOLD_EN
      check_eq("hold_count", n_hold, 1);
      check_eq("hold_delay", hold_at - rise_at, 32'(HOLD_MAX));
`else
      check_eq("hold_off_count", n_hold, 0);
      check_eq("hold_off_rise", rise_at, 32'(SYNC + STABLE));
`endif

      // Reset in the middle of WAIT1 on channel 3.
      repeat (12) tick(4'b0000);
      repeat (5) tick(4'b1000);
      reset_dut();
      lat = 0;
      for (int i = 1; i <= 14; i++) begin
         tick(4'b1000);
         if (db_rise[3] && lat == 0) lat = i;
      end
      check_eq("rst_mid_latency", lat, 32'(SYNC + STABLE));

      // Random per-channel segments of 1..14 cycles: mix of glitches and presses.
      for (int i = 0; i < N_CH; i++) rem[i] = 0;
      rv = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N_CH; i++) begin
            if (rem[i] == 0) begin
               rv[i]  = 1'($urandom_range(0, 1));
               rem[i] = $urandom_range(1, 14);
            end
            rem[i]--;
         end
         tick(rv);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
      $finish;
   end

endmodule : tb_debounce_multi
